load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Initiator side of the word-wide data memory interface (rd, wr, d_in, address, registered d_out).
- Accepts byte, half and word load/store requests from the execute stage and sequences memory accesses.
- Converts byte addresses to word indices and performs read-modify-write for sub-word stores.
- Returns aligned, extended load data with a single-cycle response pulse.

Parameters:
- ADDR_WIDTH, 12: word-index bits driven on mem_addr; upper bits are zero.

Ports:
- CLK  input  1  clock, all logic on posedge.
- RST  input  1  reset, synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request; high only in IDLE with RST low.
- req_wr  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  load result; 0 for stores and errors.
- resp_err  output  1  misaligned or illegal size; qualified by resp_valid.
- mem_rd  output  1  to memory rd.
- mem_wr  output  1  to memory wr.
- mem_addr  output  32  to memory address lines; holds {0, req_addr[ADDR_WIDTH+1:2]}.
- mem_din  output  32  to memory d_in.
- mem_dout  input  32  from memory d_out; valid the cycle after mem_rd is sampled.

Behaviour:
- Reset values:
  - State is IDLE.
  - mem_rd, mem_wr, resp_valid and resp_err are 0.
  - mem_addr, mem_din and resp_rdata are 0.
  - req_ready is 0 while RST is high.
- Memory-control gating:
  - mem_rd and mem_wr are registered.
  - mem_wr is additionally gated combinationally with ~RST, so no write reaches the memory at an edge where RST is high.
  - mem_rd and mem_wr are never high together.
- Request capture:
  - Accept edge = posedge with req_valid and req_ready both high.
  - At the accept edge, addr, size, wr and wdata are captured into registers.
  - Inputs are ignored at all other times.
- Error check, at the accept edge:
  - Error when size = 3, or half with addr[0] = 1, or word with addr[1:0] != 0.
  - Next state is RESP with resp_err = 1 and no memory access.
  - resp_valid is high in cycle 1 after acceptance.
- States: IDLE, RD, WAIT, WR, RESP.
  - IDLE -> RD: load, or store with size byte/half.
  - IDLE -> WR: store with size word; mem_din = wdata.
  - IDLE -> RESP: error.
  - RD: mem_rd = 1 for exactly one cycle; next state WAIT.
  - WAIT -> RESP (load): mem_dout is sampled into the result at this edge.
  - WAIT -> WR (store): the merged word is written into mem_din at this edge.
  - WR: mem_wr = 1 for one cycle; next state RESP.
  - RESP: resp_valid = 1 for one cycle; next state IDLE. req_ready returns high the following cycle.
- Latency, in edges from accept to resp_valid high:
  - Load: 3.
  - Word store: 2.
  - Sub-word store: 4.
  - Error: 1.
- Byte lanes are little-endian:
  - A byte at addr[1:0] = k occupies bits [8k+7:8k].
  - A half at addr[1] = h occupies bits [16h+15:16h].
- Load extraction:
  - The selected lane is shifted to bit 0.
  - Upper bits are filled per the Optional Feature.
  - A word load passes through unchanged.
- Store merge: only the addressed lane of the read word is replaced with the low bits of wdata; the other lanes are preserved.
- No back-pressure on the response path: resp_valid is not held.
- Reset mid-operation:
  - The operation aborts and the state returns to IDLE.
  - No response is produced for the aborted request.
  - A pending WR does not write.
- Address wrap: bits above ADDR_WIDTH+1 are discarded, so mem_addr aliases modulo 2^ADDR_WIDTH words.

Optional Feature:
- Macro: LSU_SIGNED_LOAD_EN.
- Defined: byte and half loads are sign-extended from bit 7 and bit 15 respectively.
- Undefined: byte and half loads are zero-extended.
- Word loads and stores are unaffected either way.

Test Plan:
- Reset then idle:
  - Assert RST for 2 cycles and release.
  - Required: req_ready = 1, all mem_* outputs = 0, resp_valid = 0.
- Word round-trip:
  - Store word 0xDEADBEEF at addr 0x10.
  - Required: mem_wr pulses with mem_addr = 4 and mem_din = 0xDEADBEEF; resp_valid 2 edges after accept.
  - Then load word from 0x10.
  - Required: resp_rdata = 0xDEADBEEF, 3 edges after accept.
- Byte store RMW:
  - Memory word 4 = 0x11223344; store byte 0xAA at addr 0x12.
  - Required: mem_rd then mem_wr, with mem_din = 0x11AA3344; resp_valid 4 edges after accept.
- Half load extension:
  - Memory word 1 = 0x8001_7FFF; load half at addr 0x6.
  - Required: resp_rdata = 0xFFFF8001 with LSU_SIGNED_LOAD_EN, 0x00008001 without.
- Errors:
  - Load word at 0x2, and separately any request with size = 3.
  - Required: resp_valid with resp_err = 1 one edge after accept, resp_rdata = 0, and no mem_rd/mem_wr pulse.
- Reset mid-store:
  - Assert RST during the WAIT state of a byte store to 0x12.
  - Required: mem_wr never high, no resp_valid, memory word unchanged, req_ready = 1 after RST is released.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: initiator for a word-wide data memory, sequencing byte/half/word loads and stores.
// Optional macro LSU_SIGNED_LOAD_EN sign-extends byte and half loads; zero-extended when undefined.
module load_store_unit #(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

`ifdef LSU_SIGNED_LOAD_EN
    localparam logic SignExt = 1'b1;
`else
    localparam logic SignExt = 1'b0;
`endif

    typedef enum logic [2:0] {StIdle, StRd, StWait, StWr, StResp} state_e;

    state_e      state;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic        wr_q;
    logic [31:0] wdata_q;
    logic        mem_wr_q;

    logic        req_err;
    logic [15:0] shifted;
    logic [31:0] load_val;
    logic [31:0] lane_mask;
    logic [31:0] merged;
    logic        unused_addr;

    // Address bits above the word index are dropped, so accesses alias.
    assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];

    assign req_ready = (state == StIdle) & ~RST;
    assign mem_wr    = mem_wr_q & ~RST;

    assign req_err = (req_size == 2'd3) ||
                     (req_size == 2'd1 && req_addr[0]) ||
                     (req_size == 2'd2 && req_addr[1:0] != 2'b00);

    always_comb begin
        shifted = 16'(mem_dout >> {lane_q, 3'b000});
        case (size_q)
            2'd0:    load_val = {{24{SignExt & shifted[7]}}, shifted[7:0]};
            2'd1:    load_val = {{16{SignExt & shifted[15]}}, shifted};
            default: load_val = mem_dout;
        endcase
    end

    always_comb begin
        if (size_q == 2'd0) begin
            lane_mask = 32'h0000_00ff << {lane_q, 3'b000};
        end else begin
            lane_mask = 32'h0000_ffff << {lane_q, 3'b000};
        end
        merged = (mem_dout & ~lane_mask) | ((wdata_q << {lane_q, 3'b000}) & lane_mask);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= StIdle;
            size_q     <= 2'd0;
            lane_q     <= 2'd0;
            wr_q       <= 1'b0;
            wdata_q    <= 32'd0;
            mem_rd     <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr   <= 32'd0;
            mem_din    <= 32'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            mem_rd     <= 1'b0;
            mem_wr_q   <= 1'b0;
            resp_valid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (req_valid) begin
                        size_q     <= req_size;
                        lane_q     <= req_addr[1:0];
                        wr_q       <= req_wr;
                        wdata_q    <= req_wdata;
                        mem_addr   <= 32'(req_addr[ADDR_WIDTH+1:2]);
                        resp_rdata <= 32'd0;
                        resp_err   <= req_err;
                        if (req_err) begin
                            state      <= StResp;
                            resp_valid <= 1'b1;
                        end else if (req_wr && req_size == 2'd2) begin
                            state    <= StWr;
                            mem_wr_q <= 1'b1;
                            mem_din  <= req_wdata;
                        end else begin
                            state  <= StRd;
                            mem_rd <= 1'b1;
                        end
                    end
                end
                StRd: begin
                    state <= StWait;
                end
                StWait: begin
                    // Read data is valid now: either finish the load or merge for the store.
                    if (wr_q) begin
                        mem_din  <= merged;
                        mem_wr_q <= 1'b1;
                        state    <= StWr;
                    end else begin
                        resp_rdata <= load_val;
                        resp_valid <= 1'b1;
                        state      <= StResp;
                    end
                end
                StWr: begin
                    resp_valid <= 1'b1;
                    state      <= StResp;
                end
                StResp: begin
                    resp_err <= 1'b0;
                    state    <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
